// File: rtl/mem_stack_stage_pkg.sv
// Shared encodings for the memory/stack pipeline stage.
package mem_pkg;

  // Wide-operation sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PUSHW2 = 2'd1;
  localparam logic [1:0] ST_POPW2  = 2'd2;

  // Resolved operation for the current cycle, one-hot inputs collapsed by priority
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_POPW  = 3'd1;
  localparam logic [2:0] OP_PUSHW = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_PUSH  = 3'd4;
  localparam logic [2:0] OP_READ  = 3'd5;
  localparam logic [2:0] OP_WRITE = 3'd6;

  // Memory write-data source
  localparam logic [1:0] WSEL_SINGLE = 2'd0;
  localparam logic [1:0] WSEL_HI     = 2'd1;
  localparam logic [1:0] WSEL_LO     = 2'd2;

  // pop_wide > push_wide > pop > push > read > write
  function automatic logic [2:0] decode_op(input logic popw, input logic pushw,
                                           input logic pop, input logic push,
                                           input logic rd, input logic wr);
    if (popw)       return OP_POPW;
    else if (pushw) return OP_PUSHW;
    else if (pop)   return OP_POP;
    else if (push)  return OP_PUSH;
    else if (rd)    return OP_READ;
    else if (wr)    return OP_WRITE;
    else            return OP_NONE;
  endfunction

endpackage

// File: rtl/mem_stack_stage_stack_ptr_ctrl.sv
// Stack pointer, limit checks and the two-cycle wide push/pop sequencer.
import mem_pkg::*;

module stack_ptr_ctrl #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned SP_RESET    = 2**ADDR_W-1,
  parameter int unsigned STACK_LIMIT = 2**(ADDR_W-1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic [ADDR_W-1:0] stack_addr_o,
  output logic              stack_sel_o,
  output logic              mem_we_o,
  output logic [1:0]        wsel_o,
  output logic              load_o,
  output logic              pop_lo_o,
  output logic              pop_hi_o,
  output logic              stall_o,
  output logic              ovf_o,
  output logic              unf_o
);

  localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(SP_RESET);
  localparam logic [ADDR_W-1:0] SP_LIM = ADDR_W'(STACK_LIMIT);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO    = ADDR_W'(2);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] sp_dec, sp_inc;

  assign sp_dec = sp_q - ONE;
  assign sp_inc = sp_q + ONE;
  assign sp_o   = sp_q;

  // Next-state, SP update and memory control for the resolved operation
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    stack_addr_o = sp_q;
    stack_sel_o  = 1'b0;
    mem_we_o     = 1'b0;
    wsel_o       = WSEL_SINGLE;
    load_o       = 1'b0;
    pop_lo_o     = 1'b0;
    pop_hi_o     = 1'b0;
    stall_o      = 1'b0;
    ovf_o        = 1'b0;
    unf_o        = 1'b0;
    case (state_q)
      ST_PUSHW2: begin
        stack_sel_o  = 1'b1;
        stack_addr_o = sp_dec;
        mem_we_o     = 1'b1;
        wsel_o       = WSEL_LO;
        sp_d         = sp_dec;
        state_d      = ST_IDLE;
      end
      ST_POPW2: begin
        stack_sel_o = 1'b1;
        pop_hi_o    = 1'b1;
        sp_d        = sp_inc;
        state_d     = ST_IDLE;
      end
      default: begin
        case (op_i)
          OP_POPW: begin
            if ((SP_TOP - sp_q) < TWO) begin
              unf_o = 1'b1;
            end else begin
              stack_sel_o = 1'b1;
              pop_lo_o    = 1'b1;
              sp_d        = sp_inc;
              stall_o     = 1'b1;
              state_d     = ST_POPW2;
            end
          end
          OP_PUSHW: begin
            if ((sp_q - SP_LIM) < TWO) begin
              ovf_o = 1'b1;
            end else begin
              stack_sel_o  = 1'b1;
              stack_addr_o = sp_dec;
              mem_we_o     = 1'b1;
              wsel_o       = WSEL_HI;
              sp_d         = sp_dec;
              stall_o      = 1'b1;
              state_d      = ST_PUSHW2;
            end
          end
          OP_POP: begin
            if (sp_q == SP_TOP) begin
              unf_o = 1'b1;
            end else begin
              stack_sel_o = 1'b1;
              load_o      = 1'b1;
              sp_d        = sp_inc;
            end
          end
          OP_PUSH: begin
            if (sp_q == SP_LIM) begin
              ovf_o = 1'b1;
            end else begin
              stack_sel_o  = 1'b1;
              stack_addr_o = sp_dec;
              mem_we_o     = 1'b1;
              sp_d         = sp_dec;
            end
          end
          OP_READ:  load_o   = 1'b1;
          OP_WRITE: mem_we_o = 1'b1;
          default:  ;
        endcase
      end
    endcase
  end

  // SP and sequencer state; reset abandons any half-finished wide op
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sp_q    <= SP_TOP;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
    end
  end

endmodule

// File: rtl/var_reg.sv
// Generic enabled register with synchronous active-high clear.
module var_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable, clear on reset
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_stack_stage.sv
// Memory pipeline stage: data memory, descending stack, stage registers to write-back.
import mem_pkg::*;

module mem_stack_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned SP_RESET    = 2**ADDR_W-1,
  parameter int unsigned STACK_LIMIT = 2**(ADDR_W-1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                memory_read,
  input  logic                memory_write,
  input  logic                memory_push,
  input  logic                memory_pop,
  input  logic                memory_push_wide,
  input  logic                memory_pop_wide,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [2*DATA_W-1:0] write_data_wide,
  input  logic                RegWrite,
  input  logic [REG_AW-1:0]   reg_write_address_from_ex,
  output logic                stall,
  output logic [DATA_W-1:0]   data_r,
  output logic [2*DATA_W-1:0] data_wide_r,
  output logic                RegWrite_r,
  output logic [REG_AW-1:0]   reg_write_address_r_to_wb,
  output logic                stack_ovf_r,
  output logic                stack_unf_r,
  output logic [ADDR_W-1:0]   sp
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [2:0]        op;
  logic [ADDR_W-1:0] stack_addr, mem_addr;
  logic              stack_sel, mem_we, load, pop_lo, pop_hi, ovf, unf;
  logic [1:0]        wsel;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, hold_lo_q;
  logic [REG_AW+2:0] ctl_q;

  assign op = decode_op(memory_pop_wide, memory_push_wide, memory_pop,
                        memory_push, memory_read, memory_write);

  stack_ptr_ctrl #(
    .ADDR_W      (ADDR_W),
    .SP_RESET    (SP_RESET),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_spc (
    .clk          (clk),
    .reset        (reset),
    .op_i         (op),
    .sp_o         (sp),
    .stack_addr_o (stack_addr),
    .stack_sel_o  (stack_sel),
    .mem_we_o     (mem_we),
    .wsel_o       (wsel),
    .load_o       (load),
    .pop_lo_o     (pop_lo),
    .pop_hi_o     (pop_hi),
    .stall_o      (stall),
    .ovf_o        (ovf),
    .unf_o        (unf)
  );

  assign mem_addr  = stack_sel ? stack_addr : address;
  assign mem_rdata = mem_q[mem_addr];

  // Select the word to store: single data, or one half of the wide word
  always_comb begin
    mem_wdata = write_data;
    case (wsel)
      WSEL_HI: mem_wdata = write_data_wide[2*DATA_W-1:DATA_W];
      WSEL_LO: mem_wdata = write_data_wide[DATA_W-1:0];
      default: ;
    endcase
  end

  // Array write; gated by reset so an abandoned wide push leaves no second half
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_addr] <= mem_wdata;
  end

  var_reg #(.W(DATA_W)) u_data_r (
    .clk (clk), .reset (reset), .en (load), .d (mem_rdata), .q (data_r)
  );

  var_reg #(.W(DATA_W)) u_hold_lo (
    .clk (clk), .reset (reset), .en (pop_lo), .d (mem_rdata), .q (hold_lo_q)
  );

  var_reg #(.W(2*DATA_W)) u_data_wide_r (
    .clk (clk), .reset (reset), .en (pop_hi), .d ({mem_rdata, hold_lo_q}), .q (data_wide_r)
  );

  // First cycle of a wide op (stall high) becomes a write-back bubble
  var_reg #(.W(REG_AW+3)) u_ctl_r (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     ({RegWrite & ~stall, reg_write_address_from_ex, ovf, unf}),
    .q     (ctl_q)
  );

  assign RegWrite_r                = ctl_q[REG_AW+2];
  assign reg_write_address_r_to_wb = ctl_q[REG_AW+1:2];
  assign stack_ovf_r               = ctl_q[1];
  assign stack_unf_r               = ctl_q[0];

endmodule

// File: tb/tb_mem_stack_stage.sv
// Scoreboard bench for mem_stack_stage: driver queues expectations, monitor checks them.
module tb_mem_stack_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned REG_AW = 3;

  localparam int K_DATA  = 0;
  localparam int K_WIDE  = 1;
  localparam int K_REGW  = 2;
  localparam int K_REGA  = 3;
  localparam int K_OVF   = 4;
  localparam int K_UNF   = 5;
  localparam int K_SP    = 6;
  localparam int K_STALL = 7;

  logic                clk = 1'b0;
  logic                reset;
  logic                memory_read, memory_write, memory_push, memory_pop;
  logic                memory_push_wide, memory_pop_wide;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   write_data;
  logic [2*DATA_W-1:0] write_data_wide;
  logic                RegWrite;
  logic [REG_AW-1:0]   reg_write_address_from_ex;
  logic                stall;
  logic [DATA_W-1:0]   data_r;
  logic [2*DATA_W-1:0] data_wide_r;
  logic                RegWrite_r;
  logic [REG_AW-1:0]   reg_write_address_r_to_wb;
  logic                stack_ovf_r, stack_unf_r;
  logic [ADDR_W-1:0]   sp;

  mem_stack_stage #(
    .DATA_W      (16),
    .ADDR_W      (11),
    .REG_AW      (3),
    .SP_RESET    (2047),
    .STACK_LIMIT (1024)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .memory_read               (memory_read),
    .memory_write              (memory_write),
    .memory_push               (memory_push),
    .memory_pop                (memory_pop),
    .memory_push_wide          (memory_push_wide),
    .memory_pop_wide           (memory_pop_wide),
    .address                   (address),
    .write_data                (write_data),
    .write_data_wide           (write_data_wide),
    .RegWrite                  (RegWrite),
    .reg_write_address_from_ex (reg_write_address_from_ex),
    .stall                     (stall),
    .data_r                    (data_r),
    .data_wide_r               (data_wide_r),
    .RegWrite_r                (RegWrite_r),
    .reg_write_address_r_to_wb (reg_write_address_r_to_wb),
    .stack_ovf_r               (stack_ovf_r),
    .stack_unf_r               (stack_unf_r),
    .sp                        (sp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_DATA:  return 32'(data_r);
      K_WIDE:  return data_wide_r;
      K_REGW:  return 32'(RegWrite_r);
      K_REGA:  return 32'(reg_write_address_r_to_wb);
      K_OVF:   return 32'(stack_ovf_r);
      K_UNF:   return 32'(stack_unf_r);
      K_SP:    return 32'(sp);
      default: return 32'(stall);
    endcase
  endfunction

  // Expected value for a given output, due 'off' cycles from now
  task automatic sb_push(input int kind, input logic [31:0] v, input int off, input string name);
    sb.push_back('{cyc + off, kind, v, name});
  endtask

  // Monitor: on each falling edge, check every expectation that has come due
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        n_cmp++;
        if (sb[i].due < cyc || actual(sb[i].kind) !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s (cycle %0d): got %h expected %h",
                   sb[i].name, cyc, actual(sb[i].kind), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    memory_read = 1'b0; memory_write = 1'b0; memory_push = 1'b0; memory_pop = 1'b0;
    memory_push_wide = 1'b0; memory_pop_wide = 1'b0;
  endtask

  task automatic check_all_reset(input string tag);
    sb_push(K_DATA, 0, 0, {tag, "_data_r"});
    sb_push(K_WIDE, 0, 0, {tag, "_data_wide_r"});
    sb_push(K_REGW, 0, 0, {tag, "_RegWrite_r"});
    sb_push(K_REGA, 0, 0, {tag, "_reg_addr"});
    sb_push(K_OVF, 0, 0, {tag, "_ovf"});
    sb_push(K_UNF, 0, 0, {tag, "_unf"});
    sb_push(K_SP, 2047, 0, {tag, "_sp"});
    sb_push(K_STALL, 0, 0, {tag, "_stall"});
  endtask

  initial begin
    clear_ops();
    reset = 1'b1;
    address = '0; write_data = '0; write_data_wide = '0;
    RegWrite = 1'b0; reg_write_address_from_ex = '0;
    tick(); tick();
    reset = 1'b0;
    check_all_reset("rst");
    tick();

    // write then read back
    clear_ops(); memory_write = 1'b1; address = 11'h010; write_data = 16'hBEEF;
    tick();
    clear_ops(); memory_read = 1'b1; address = 11'h010;
    sb_push(K_DATA, 32'hBEEF, 1, "read_beef");
    tick();

    // two pushes, two pops
    clear_ops(); memory_push = 1'b1; write_data = 16'h1111;
    sb_push(K_SP, 2046, 1, "push1_sp");
    tick();
    clear_ops(); memory_push = 1'b1; write_data = 16'h2222;
    sb_push(K_SP, 2045, 1, "push2_sp");
    tick();
    clear_ops(); memory_pop = 1'b1;
    sb_push(K_DATA, 32'h2222, 1, "pop1_data");
    sb_push(K_SP, 2046, 1, "pop1_sp");
    tick();
    clear_ops(); memory_pop = 1'b1;
    sb_push(K_DATA, 32'h1111, 1, "pop2_data");
    sb_push(K_SP, 2047, 1, "pop2_sp");
    tick();

    // wide push (two cycles, inputs held), then wide pop with RegWrite bubble
    clear_ops(); memory_push_wide = 1'b1; write_data_wide = 32'hAAAA5555;
    sb_push(K_STALL, 1, 0, "pushw_stall1");
    sb_push(K_SP, 2046, 1, "pushw_sp1");
    tick();
    sb_push(K_STALL, 0, 0, "pushw_stall2");
    sb_push(K_SP, 2045, 1, "pushw_sp2");
    tick();
    clear_ops(); memory_pop_wide = 1'b1; RegWrite = 1'b1; reg_write_address_from_ex = 3'd3;
    sb_push(K_STALL, 1, 0, "popw_stall1");
    sb_push(K_REGW, 0, 1, "popw_bubble");
    tick();
    sb_push(K_STALL, 0, 0, "popw_stall2");
    sb_push(K_REGW, 1, 1, "popw_regw");
    sb_push(K_REGA, 3, 1, "popw_rega");
    sb_push(K_WIDE, 32'hAAAA5555, 1, "popw_wide");
    sb_push(K_SP, 2047, 1, "popw_sp");
    tick();
    RegWrite = 1'b0; reg_write_address_from_ex = '0;

    // wide push, then single pops show word order (low half on top)
    clear_ops(); memory_push_wide = 1'b1; write_data_wide = 32'h12345678;
    tick(); tick();
    clear_ops(); memory_pop = 1'b1;
    sb_push(K_DATA, 32'h5678, 1, "pushw_lo_top");
    tick();
    sb_push(K_DATA, 32'h1234, 1, "pushw_hi_below");
    tick();

    // underflow on empty stack
    clear_ops(); memory_pop = 1'b1;
    sb_push(K_UNF, 1, 1, "unf_pulse");
    sb_push(K_SP, 2047, 1, "unf_sp");
    sb_push(K_DATA, 32'h1234, 1, "unf_data_hold");
    tick();
    clear_ops();
    sb_push(K_UNF, 0, 1, "unf_clear");
    tick();

    // fill to the limit
    for (int i = 0; i < 1023; i++) begin
      clear_ops(); memory_push = 1'b1; write_data = 16'(i + 'h100);
      tick();
    end
    clear_ops();
    sb_push(K_SP, 1024, 0, "fill_sp");
    memory_push = 1'b1; write_data = 16'hDEAD;
    sb_push(K_OVF, 1, 1, "ovf_pulse");
    sb_push(K_SP, 1024, 1, "ovf_sp");
    tick();
    clear_ops(); memory_read = 1'b1; address = 11'd1024;
    sb_push(K_DATA, 32'h04FE, 1, "ovf_mem_kept");
    sb_push(K_OVF, 0, 1, "ovf_clear");
    tick();
    clear_ops(); memory_pop = 1'b1;
    sb_push(K_DATA, 32'h04FE, 1, "pop_at_limit");
    sb_push(K_SP, 1025, 1, "pop_at_limit_sp");
    tick();

    // wide push with only one free slot overflows, writes nothing
    clear_ops(); memory_push_wide = 1'b1; write_data_wide = 32'hCAFEF00D;
    sb_push(K_STALL, 0, 0, "pushw_ovf_nostall");
    sb_push(K_OVF, 1, 1, "pushw_ovf_pulse");
    sb_push(K_SP, 1025, 1, "pushw_ovf_sp");
    tick();
    clear_ops(); memory_read = 1'b1; address = 11'd1024;
    sb_push(K_DATA, 32'h04FE, 1, "pushw_ovf_nowrite");
    tick();

    // pop beats read; write-back control passes through
    clear_ops(); memory_pop = 1'b1; memory_read = 1'b1; address = 11'h010;
    RegWrite = 1'b1; reg_write_address_from_ex = 3'd5;
    sb_push(K_DATA, 32'h04FD, 1, "prio_pop_data");
    sb_push(K_SP, 1026, 1, "prio_pop_sp");
    sb_push(K_REGW, 1, 1, "prio_regw");
    sb_push(K_REGA, 5, 1, "prio_rega");
    tick();
    clear_ops(); RegWrite = 1'b0; reg_write_address_from_ex = 3'd6;
    sb_push(K_REGW, 0, 1, "regw_follow");
    sb_push(K_REGA, 6, 1, "rega_follow");
    tick();

    // reset in the middle of a wide push
    clear_ops(); memory_push_wide = 1'b1; write_data_wide = 32'h13572468;
    tick();
    clear_ops(); reset = 1'b1;
    tick();
    reset = 1'b0; reg_write_address_from_ex = '0;
    check_all_reset("rst_pushw2");
    tick();

    // wide pop with a single word on the stack underflows
    clear_ops(); memory_push = 1'b1; write_data = 16'h7777;
    tick();
    clear_ops(); memory_pop_wide = 1'b1;
    sb_push(K_STALL, 0, 0, "popw_unf_nostall");
    sb_push(K_UNF, 1, 1, "popw_unf_pulse");
    sb_push(K_SP, 2046, 1, "popw_unf_sp");
    tick();
    clear_ops(); memory_pop = 1'b1;
    sb_push(K_DATA, 32'h7777, 1, "after_popw_unf");
    sb_push(K_SP, 2047, 1, "after_popw_unf_sp");
    tick();

    clear_ops();
    tick(); tick(); tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
